// File: rtl/univ_mod_counter.sv
// Up/down modulo-M counter with load, clear, enable,
// terminal ticks, registered wrap pulses and sticky flags.
module univ_mod_counter #(
  parameter int N = 8,
  parameter int M = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  input  logic         clr_flags,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         wrap_up,
  output logic         wrap_dn,
  output logic         ovf,
  output logic         unf
);

  localparam logic [N-1:0] MAX = N'(M - 1);
  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] q_q, q_d;
  logic         wu_q, wu_d;
  logic         wd_q, wd_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;

  always_comb begin
    q_d  = q_q;
    wu_d = 1'b0;
    wd_d = 1'b0;
    if (syn_clr) begin
      q_d = '0;
    end else if (load) begin
      // out-of-range loads clamp to the top of the count range
      q_d = (d > MAX) ? MAX : d;
    end else if (en && up) begin
      if (q_q == MAX) begin
        q_d  = '0;
        wu_d = 1'b1;
      end else begin
        q_d = q_q + ONE;
      end
    end else if (en) begin
      if (q_q == '0) begin
        q_d  = MAX;
        wd_d = 1'b1;
      end else begin
        q_d = q_q - ONE;
      end
    end
    ovf_d = wu_d | (ovf_q & ~clr_flags);
    unf_d = wd_d | (unf_q & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q   <= '0;
      wu_q  <= 1'b0;
      wd_q  <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      wu_q  <= wu_d;
      wd_q  <= wd_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign q        = q_q;
  assign max_tick = (q_q == MAX);
  assign min_tick = (q_q == '0);
  assign wrap_up  = wu_q;
  assign wrap_dn  = wd_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: tb/tb_univ_mod_counter.sv
// Bench for univ_mod_counter (N=8, M=10): directed
// vector table plus randomized run against a model.
module tb_univ_mod_counter;

  localparam int N = 8;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset, syn_clr, load, en, up, clr_flags;
  logic [N-1:0] d;
  logic [N-1:0] q;
  logic         max_tick, min_tick, wrap_up, wrap_dn, ovf, unf;

  int checks = 0;
  int failures = 0;

  int m_q;
  bit m_wu, m_wd, m_ovf, m_unf;

  typedef struct {
    bit rst_n, clr, ld, en, up, cf;
    int d;
    int q;
    bit wu, wd, ovf, unf;
  } vec_t;

  vec_t vecs[$];

  univ_mod_counter #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset), .syn_clr(syn_clr),
    .load(load), .en(en), .up(up), .d(d),
    .clr_flags(clr_flags), .q(q),
    .max_tick(max_tick), .min_tick(min_tick),
    .wrap_up(wrap_up), .wrap_dn(wrap_dn),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(bit rst_n, bit clr, bit ld, bit e,
                     bit u, int dv, bit cf, int eq,
                     bit ewu, bit ewd, bit eo, bit eu);
    vec_t v;
    v.rst_n = rst_n; v.clr = clr; v.ld = ld;
    v.en = e; v.up = u; v.d = dv; v.cf = cf;
    v.q = eq; v.wu = ewu; v.wd = ewd;
    v.ovf = eo; v.unf = eu;
    vecs.push_back(v);
  endtask

  // reference: spec rules in plain modular arithmetic
  task automatic model_edge();
    if (!reset) begin
      m_q = 0; m_wu = 0; m_wd = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_wu = 0; m_wd = 0;
      if (syn_clr) m_q = 0;
      else if (load) m_q = (int'(d) > M - 1) ? M - 1 : int'(d);
      else if (en && up) begin
        m_wu = (m_q == M - 1);
        m_q = (m_q + 1) % M;
      end else if (en) begin
        m_wd = (m_q == 0);
        m_q = (m_q + M - 1) % M;
      end
      m_ovf = m_wu || (m_ovf && !clr_flags);
      m_unf = m_wd || (m_unf && !clr_flags);
    end
  endtask

  task automatic drive(bit rst_n, bit clr, bit ld, bit e,
                       bit u, int dv, bit cf);
    reset = rst_n; syn_clr = clr; load = ld;
    en = e; up = u; d = N'(dv); clr_flags = cf;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cmp_all(string tag, int eq, bit ewu,
                         bit ewd, bit eo, bit eu);
    chk({tag, " q"}, int'(q), eq);
    chk({tag, " max_tick"}, int'(max_tick), int'(eq == M - 1));
    chk({tag, " min_tick"}, int'(min_tick), int'(eq == 0));
    chk({tag, " wrap_up"}, int'(wrap_up), int'(ewu));
    chk({tag, " wrap_dn"}, int'(wrap_dn), int'(ewd));
    chk({tag, " ovf"}, int'(ovf), int'(eo));
    chk({tag, " unf"}, int'(unf), int'(eu));
  endtask

  initial begin
    reset = 0; syn_clr = 0; load = 0; en = 0;
    up = 0; d = '0; clr_flags = 0;
    @(negedge clk);

    add(0,0,0,0,0,0,0, 0,0,0,0,0);
    for (int i = 1; i <= 12; i++)
      add(1,0,0,1,1,0,0, i % 10, i == 10, 0, i >= 10, 0);
    add(1,0,0,1,0,0,0, 1,0,0,1,0);
    add(1,0,0,1,0,0,0, 0,0,0,1,0);
    add(1,0,0,1,0,0,0, 9,0,1,1,1);
    add(1,0,0,1,0,0,0, 8,0,0,1,1);
    add(1,0,0,1,0,0,0, 7,0,0,1,1);
    add(1,0,0,1,0,0,0, 6,0,0,1,1);
    add(1,0,1,0,0,3,0, 3,0,0,1,1);
    add(1,0,0,1,1,0,0, 4,0,0,1,1);
    add(1,0,0,1,1,0,0, 5,0,0,1,1);
    add(1,0,1,0,0,200,0, 9,0,0,1,1);
    add(1,1,0,1,1,0,0, 0,0,0,1,1);
    add(1,0,0,1,1,0,0, 1,0,0,1,1);
    add(1,0,0,1,1,0,0, 2,0,0,1,1);
    add(1,0,0,1,1,0,0, 3,0,0,1,1);
    add(1,0,0,0,0,0,1, 3,0,0,0,0);
    add(1,0,1,0,0,9,0, 9,0,0,0,0);
    add(1,0,0,1,1,0,1, 0,1,0,1,0);
    for (int i = 1; i <= 5; i++)
      add(1,0,0,1,1,0,0, i,0,0,1,0);
    add(0,0,1,1,1,7,0, 0,0,0,0,0);
    for (int i = 1; i <= 5; i++)
      add(1,0,0,1,1,0,0, i,0,0,0,0);
    add(1,0,1,0,0,10,0, 9,0,0,0,0);
    add(1,0,1,0,0,0,0, 0,0,0,0,0);
    add(1,0,0,1,0,0,0, 9,0,1,0,1);
    add(1,0,0,0,1,0,0, 9,0,0,0,1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].clr, vecs[i].ld,
            vecs[i].en, vecs[i].up, vecs[i].d, vecs[i].cf);
      cmp_all($sformatf("vec%0d", i), vecs[i].q,
              vecs[i].wu, vecs[i].wd,
              vecs[i].ovf, vecs[i].unf);
    end

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(31) != 0,
            $urandom_range(15) == 0,
            $urandom_range(7) == 0,
            $urandom_range(3) != 0,
            $urandom_range(1) == 1,
            int'($urandom_range(255)),
            $urandom_range(15) == 0);
      cmp_all($sformatf("rnd%0d", i), m_q,
              m_wu, m_wd, m_ovf, m_unf);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
